// File: rtl/cceip_kernel_ar_pkg.sv
// Shared types and default geometry for the kernel AXI4 read-request issuer.
package cceip_kernel_ar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } ar_state_t;

  localparam int LP_DATA_WIDTH        = 512;
  localparam int LP_BURST_LEN         = 64;
  localparam int LP_MAX_OUTSTANDING   = 16;
  localparam int LP_BYTES_PER_BEAT    = LP_DATA_WIDTH / 8;
  localparam int LP_BURST_BYTES       = LP_BYTES_PER_BEAT * LP_BURST_LEN;
  localparam int LP_LOG_BURST_BYTES   = $clog2(LP_BURST_BYTES);
  localparam int LP_OUTSTANDING_WIDTH = $clog2(LP_MAX_OUTSTANDING) + 1;

endpackage

// File: rtl/cceip_kernel_example_counter.sv
// Up/down counter with synchronous load; incr and decr together cancel.
module cceip_kernel_example_counter #(
  parameter int C_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               incr,
  input  logic               decr,
  input  logic [C_WIDTH-1:0] load_value,
  output logic [C_WIDTH-1:0] count
);

  // Count register: load wins, otherwise net +1 / -1 / hold.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (incr && !decr) begin
      count <= count + 1'b1;
    end else if (decr && !incr) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/cceip_kernel_example_ar_issuer.sv
// Splits one (address, byte-length) command into aligned AXI4 AR bursts,
// throttles outstanding bursts and pulses ctrl_done after the last RLAST.
module cceip_kernel_example_ar_issuer
  import cceip_kernel_ar_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = LP_DATA_WIDTH,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = LP_BURST_LEN,
  parameter int C_MAX_OUTSTANDING = LP_MAX_OUTSTANDING
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
  output logic                         busy,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         r_burst_done
);

  localparam int BEAT_BYTES  = C_DATA_WIDTH / 8;
  localparam int LOG_BEAT    = $clog2(BEAT_BYTES);
  localparam int LOG_BLEN    = $clog2(C_BURST_LEN);
  localparam int BURST_BYTES = BEAT_BYTES * C_BURST_LEN;
  localparam int OUT_W       = $clog2(C_MAX_OUTSTANDING) + 1;
  // One extra bit so a maximal size cannot overflow the rounding adds.
  localparam int CNT_W       = C_XFER_SIZE_WIDTH + 1;

  ar_state_t                    state, state_nxt;
  logic [C_XFER_SIZE_WIDTH-1:0] size_q;
  logic [7:0]                   last_len_q;
  logic [CNT_W-1:0]             beats, bursts;
  logic [7:0]                   last_len;
  logic [CNT_W-1:0]             issue_count, comp_count;
  logic [OUT_W-1:0]             out_count;
  logic                         ar_hs, r_ok, setup_load;

  assign beats    = ({1'b0, size_q} + CNT_W'(BEAT_BYTES - 1)) >> LOG_BEAT;
  assign bursts   = (beats + CNT_W'(C_BURST_LEN - 1)) >> LOG_BLEN;
  assign last_len = 8'(beats - 1'b1) & 8'(C_BURST_LEN - 1);

  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  // RLAST outside an active transfer is a protocol error and moves nothing.
  assign r_ok       = r_burst_done && ((state == S_ISSUE) || (state == S_DRAIN));
  assign setup_load = (state == S_SETUP);

  assign ctrl_done   = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign m_axi_arlen = (state != S_ISSUE)         ? 8'd0 :
                       (issue_count == CNT_W'(1)) ? last_len_q :
                                                    8'(C_BURST_LEN - 1);

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Command capture, final-burst length and burst address advance.
  always_ff @(posedge aclk) begin
    if (areset) begin
      size_q       <= '0;
      last_len_q   <= '0;
      m_axi_araddr <= '0;
    end else begin
      if (state == S_IDLE && ctrl_start) begin
        size_q       <= ctrl_xfer_size_in_bytes;
        m_axi_araddr <= ctrl_addr_offset;
      end
      if (setup_load) last_len_q <= last_len;
      if (ar_hs)      m_axi_araddr <= m_axi_araddr + C_ADDR_WIDTH'(BURST_BYTES);
    end
  end

  // Next-state and AR valid. arvalid only rises below the limit and the count
  // only grows on a handshake, so a raised arvalid cannot fall without one.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    case (state)
      S_IDLE:  if (ctrl_start) state_nxt = S_SETUP;
      S_SETUP: state_nxt = (bursts == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        m_axi_arvalid = (out_count < OUT_W'(C_MAX_OUTSTANDING));
        if (ar_hs && issue_count == CNT_W'(1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (comp_count == '0 || (r_burst_done && comp_count == CNT_W'(1)))
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  cceip_kernel_example_counter #(.C_WIDTH(CNT_W)) u_issue_cnt (
    .clk        (aclk),
    .rst        (areset),
    .load       (setup_load),
    .incr       (1'b0),
    .decr       (ar_hs),
    .load_value (bursts),
    .count      (issue_count)
  );

  cceip_kernel_example_counter #(.C_WIDTH(OUT_W)) u_outstanding_cnt (
    .clk        (aclk),
    .rst        (areset),
    .load       (1'b0),
    .incr       (ar_hs),
    .decr       (r_ok),
    .load_value ('0),
    .count      (out_count)
  );

  cceip_kernel_example_counter #(.C_WIDTH(CNT_W)) u_completion_cnt (
    .clk        (aclk),
    .rst        (areset),
    .load       (setup_load),
    .incr       (1'b0),
    .decr       (r_ok),
    .load_value (bursts),
    .count      (comp_count)
  );

endmodule

// File: tb/tb_cceip_kernel_example_ar_issuer.sv
// Directed bench for the AR issuer: burst splitting, throttle, stall, reset.
module tb_cceip_kernel_example_ar_issuer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        ctrl_start;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes;
  logic        ctrl_done;
  logic        busy;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        r_burst_done;

  int n_checks = 0;
  int n_errors = 0;

  cceip_kernel_example_ar_issuer dut (
    .aclk                    (aclk),
    .areset                  (areset),
    .ctrl_start              (ctrl_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_done               (ctrl_done),
    .busy                    (busy),
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .r_burst_done            (r_burst_done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One-cycle start strobe; returns in the SETUP cycle.
  task automatic do_start(input logic [63:0] addr, input logic [31:0] size);
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start              = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic check_ar(input string tag, input logic [63:0] addr, input logic [7:0] len);
    check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd1);
    check({tag, "_araddr"}, m_axi_araddr, addr);
    check({tag, "_arlen"}, 64'(m_axi_arlen), 64'(len));
  endtask

  // Accept every AR and return RLAST while the bench-tracked outstanding
  // count is non-zero, until ctrl_done shows or the budget runs out.
  task automatic finish_cmd(input string tag, input int outst, input int budget);
    bit seen = 0;
    bit rb;
    bit hs;
    m_axi_arready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      rb           = (outst > 0);
      r_burst_done = rb;
      hs           = m_axi_arvalid;
      tick();
      outst = outst + int'(hs) - int'(rb);
      if (ctrl_done) begin
        seen = 1;
        break;
      end
    end
    r_burst_done  = 1'b0;
    m_axi_arready = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_outst_at_done"}, 64'(outst), 64'd0);
    tick();
    check({tag, "_done_one_cycle"}, 64'(ctrl_done), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int hs_cnt;
    int done_cnt;
    areset                  = 1'b1;
    ctrl_start              = 1'b0;
    ctrl_addr_offset        = '0;
    ctrl_xfer_size_in_bytes = '0;
    m_axi_arready           = 1'b0;
    r_burst_done            = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(ctrl_done), 64'd0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_arlen", 64'(m_axi_arlen), 64'd0);
    areset = 1'b0;
    tick();

    // 8192 bytes at 0x1000: two full bursts; done one cycle after last RLAST.
    do_start(64'h1000, 32'd8192);
    check("t1_setup_busy", 64'(busy), 64'd1);
    check("t1_setup_arvalid", 64'(m_axi_arvalid), 64'd0);
    tick();
    check_ar("t1_ar0", 64'h1000, 8'd63);
    m_axi_arready = 1'b1;
    tick();
    check_ar("t1_ar1", 64'h2000, 8'd63);
    tick();
    check("t1_drain_arvalid", 64'(m_axi_arvalid), 64'd0);
    m_axi_arready = 1'b0;
    r_burst_done  = 1'b1;
    tick();
    r_burst_done = 1'b0;
    check("t1_no_early_done", 64'(ctrl_done), 64'd0);
    r_burst_done = 1'b1;
    tick();
    r_burst_done = 1'b0;
    check("t1_done", 64'(ctrl_done), 64'd1);
    check("t1_done_busy", 64'(busy), 64'd1);
    tick();
    check("t1_done_drop", 64'(ctrl_done), 64'd0);
    check("t1_busy_drop", 64'(busy), 64'd0);

    // 100 bytes: 2 beats, one AR with arlen 1.
    do_start(64'h3000, 32'd100);
    tick();
    check_ar("t2_ar0", 64'h3000, 8'd1);
    m_axi_arready = 1'b1;
    tick();
    check("t2_single_ar", 64'(m_axi_arvalid), 64'd0);
    finish_cmd("t2", 1, 20);

    // 4097 bytes: 65 beats, arlen 63 then arlen 0.
    do_start(64'h20000, 32'd4097);
    tick();
    check_ar("t3_ar0", 64'h20000, 8'd63);
    m_axi_arready = 1'b1;
    tick();
    check_ar("t3_ar1", 64'h21000, 8'd0);
    tick();
    check("t3_two_ars", 64'(m_axi_arvalid), 64'd0);
    finish_cmd("t3", 2, 20);

    // Zero length: no AR, done two cycles after start, busy two cycles.
    do_start(64'h5000, 32'd0);
    check("t4_busy_c1", 64'(busy), 64'd1);
    check("t4_no_done_c1", 64'(ctrl_done), 64'd0);
    check("t4_no_ar_c1", 64'(m_axi_arvalid), 64'd0);
    tick();
    check("t4_done_c2", 64'(ctrl_done), 64'd1);
    check("t4_busy_c2", 64'(busy), 64'd1);
    check("t4_no_ar_c2", 64'(m_axi_arvalid), 64'd0);
    tick();
    check("t4_idle_busy", 64'(busy), 64'd0);
    check("t4_idle_done", 64'(ctrl_done), 64'd0);

    // 20 bursts with RLAST withheld: throttles at 16 outstanding.
    do_start(64'h0, 32'd81920);
    m_axi_arready = 1'b1;
    hs_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (m_axi_arvalid) hs_cnt++;
      tick();
    end
    check("t5_hs_at_limit", 64'(hs_cnt), 64'd16);
    check("t5_throttled", 64'(m_axi_arvalid), 64'd0);
    r_burst_done = 1'b1;
    tick();
    r_burst_done = 1'b0;
    check_ar("t5_ar16", 64'h10000, 8'd63);
    r_burst_done = 1'b1;
    tick();
    r_burst_done = 1'b0;
    check_ar("t5_coincident", 64'h11000, 8'd63);
    tick();
    check("t5_rethrottled", 64'(m_axi_arvalid), 64'd0);
    finish_cmd("t5", 16, 200);

    // arready low 10 cycles: AR stays stable, handshake on the 11th.
    do_start(64'h4000, 32'd8192);
    tick();
    m_axi_arready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("t6_stall_stable",
            64'(m_axi_arvalid && m_axi_araddr == 64'h4000 && m_axi_arlen == 8'd63), 64'd1);
      tick();
    end
    check_ar("t6_c11", 64'h4000, 8'd63);
    m_axi_arready = 1'b1;
    tick();
    check_ar("t6_after_hs", 64'h5000, 8'd63);
    finish_cmd("t6", 1, 20);

    // Reset after 3 of 5 bursts: outputs clear, no done.
    do_start(64'h0, 32'd20480);
    tick();
    m_axi_arready = 1'b1;
    hs_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_axi_arvalid) hs_cnt++;
      tick();
      if (hs_cnt == 3) break;
    end
    m_axi_arready = 1'b0;
    check("t7_three_issued", 64'(hs_cnt), 64'd3);
    areset = 1'b1;
    tick();
    check("t7_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_araddr", m_axi_araddr, 64'd0);
    check("t7_rst_arlen", 64'(m_axi_arlen), 64'd0);
    areset   = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (ctrl_done) done_cnt++;
      tick();
    end
    check("t7_no_done", 64'(done_cnt), 64'd0);

    // Fresh command; a second start while busy is ignored.
    do_start(64'h8000, 32'd100);
    tick();
    check_ar("t8_ar0", 64'h8000, 8'd1);
    m_axi_arready           = 1'b1;
    ctrl_start              = 1'b1;
    ctrl_addr_offset        = 64'hF0000;
    ctrl_xfer_size_in_bytes = 32'd8192;
    tick();
    ctrl_start = 1'b0;
    hs_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (m_axi_arvalid) hs_cnt++;
      tick();
    end
    check("t8_no_extra_ar", 64'(hs_cnt), 64'd0);
    finish_cmd("t8", 1, 20);
    hs_cnt = 0;
    m_axi_arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (m_axi_arvalid) hs_cnt++;
      tick();
    end
    m_axi_arready = 1'b0;
    check("t8_stays_idle", 64'(hs_cnt + int'(busy)), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
